// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receive core and its system-side user.
// The master drives the serial line and frame configuration and consumes the
// received byte and status pulses. The slave side is the receiver core.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VLD;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, DATA_VLD, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, DATA_VLD, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver core: oversampled start detection with glitch rejection,
// 3-sample majority voting per bit, LSB-first deserialisation, optional
// even/odd parity check and stop-bit check with one-cycle result pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | timing the start bit, majority 1 means glitch
// DATA   | shifting in DATA_WIDTH bits LSB-first
// PARITY | sampling the parity bit and recording a mismatch
// STOP   | sampling the stop bit, results issued in the next cycle
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_core_if.slave bus
);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  rx_meta;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] p_lat;
    logic [PRESCALE_W-1:0] p_last;
    logic [PRESCALE_W-1:0] p_half;
    logic [BCW-1:0]        bit_cnt;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  s_a;
    logic                  s_b;
    logic                  s_c;
    logic                  s_c_eff;
    logic                  bit_val;
    logic                  bit_end;
    logic                  bit_last;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bad;
    logic                  frame_ok;
    logic                  start_frame;
    logic                  frame_done;
    logic                  shift_en;
    logic                  par_chk;

    assign p_last   = p_lat - PRESCALE_W'(1);
    assign p_half   = p_lat >> 1;
    assign bit_end  = (edge_cnt == p_last);
    assign bit_last = (bit_cnt == BCW'(DATA_WIDTH - 1));

    // With a very small prescale the decision edge coincides with the third
    // sample, so the live line value stands in for the not-yet-stored sample.
    assign s_c_eff  = (edge_cnt == p_half + PRESCALE_W'(1)) ? rx_s : s_c;
    assign bit_val  = (s_a & s_b) | (s_a & s_c_eff) | (s_b & s_c_eff);
    assign frame_ok = bit_val && !(par_en_lat && par_bad);

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        frame_done  = 1'b0;
        shift_en    = 1'b0;
        par_chk     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_next = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_last) state_next = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_chk    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_done = 1'b1;
                    // A start bit right behind the stop bit begins the next
                    // frame immediately so back-to-back frames keep exact pitch.
                    if (!rx_s) begin
                        state_next  = START;
                        start_frame = 1'b1;
                    end else begin
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timing, sampling, frame configuration and deserialisation.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            p_lat       <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            s_a         <= 1'b1;
            s_b         <= 1'b1;
            s_c         <= 1'b1;
            shift       <= '0;
            par_bad     <= 1'b0;
        end else begin
            if (state == IDLE || bit_end) edge_cnt <= '0;
            else                          edge_cnt <= edge_cnt + PRESCALE_W'(1);

            if (state != DATA) bit_cnt <= '0;
            else if (bit_end)  bit_cnt <= bit_cnt + BCW'(1);

            if (start_frame) begin
                p_lat       <= bus.Prescale;
                par_en_lat  <= bus.PAR_EN;
                par_typ_lat <= bus.PAR_TYP;
            end

            if (edge_cnt == p_half - PRESCALE_W'(1)) s_a <= rx_s;
            if (edge_cnt == p_half)                  s_b <= rx_s;
            if (edge_cnt == p_half + PRESCALE_W'(1)) s_c <= rx_s;

            if (shift_en) shift <= {bit_val, shift[DATA_WIDTH-1:1]};

            if (start_frame)  par_bad <= 1'b0;
            else if (par_chk) par_bad <= ((^shift) ^ par_typ_lat) != bit_val;
        end
    end

    // Result pulses and received byte, issued the cycle after the stop bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.P_DATA   <= '0;
            bus.DATA_VLD <= 1'b0;
            bus.PAR_ERR  <= 1'b0;
            bus.STP_ERR  <= 1'b0;
        end else begin
            bus.DATA_VLD <= frame_done && frame_ok;
            bus.PAR_ERR  <= frame_done && par_en_lat && par_bad;
            bus.STP_ERR  <= frame_done && !bit_val;
            if (frame_done && frame_ok) bus.P_DATA <= shift;
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core: table of single frames plus
// hand-written glitch, back-to-back, break and reset sequences.
module tb_uart_rx_core;
    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    uart_rx_core_if bus ();

    uart_rx_core dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Posedge counter used to timestamp pulses.
    always @(posedge CLK) cyc <= cyc + 1;

    int         vld_cyc[$];
    logic [7:0] vld_dat[$];
    int         perr_cyc[$];
    int         serr_cyc[$];

    // Pulse monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (bus.DATA_VLD) begin
            vld_cyc.push_back(cyc);
            vld_dat.push_back(bus.P_DATA);
        end
        if (bus.PAR_ERR) perr_cyc.push_back(cyc);
        if (bus.STP_ERR) serr_cyc.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        int         p;
        logic       pe;
        logic       pt;
        logic       par_bit;
        logic       stop_bit;
        int         exp_vld;
        int         exp_perr;
        int         exp_serr;
        logic [7:0] exp_pdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        vld_cyc.delete();
        vld_dat.delete();
        perr_cyc.delete();
        serr_cyc.delete();
    endtask

    task automatic drive(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    // Caller must be at a negedge; leaves RX_IN at the stop value.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                              input logic par_bit, input logic stop_bit,
                              output int fall_cyc);
        fall_cyc = cyc;
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) drive(d[i], p);
        if (pe) drive(par_bit, p);
        drive(stop_bit, p);
    endtask

    task automatic config_frame(input int p, input logic pe, input logic pt);
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
    endtask

    int fall;
    int first;

    initial begin
        vecs[0] = '{8'hA5,  8, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 8'hA5};
        vecs[2] = '{8'h81,  8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
        vecs[3] = '{8'h81,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h81};
        vecs[4] = '{8'hC3,  8, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'hC3};
        vecs[5] = '{8'h0F,  8, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1, 8'hC3};
        vecs[6] = '{8'h6E, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'h6E};

        RST = 1'b1;
        bus.RX_IN = 1'b1;
        config_frame(8, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        check("reset_p_data",   int'(bus.P_DATA),   0);
        check("reset_data_vld", int'(bus.DATA_VLD), 0);
        check("reset_par_err",  int'(bus.PAR_ERR),  0);
        check("reset_stp_err",  int'(bus.STP_ERR),  0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        for (int v = 0; v < 7; v++) begin
            clear_mon();
            config_frame(vecs[v].p, vecs[v].pe, vecs[v].pt);
            send_frame(vecs[v].data, vecs[v].p, vecs[v].pe,
                       vecs[v].par_bit, vecs[v].stop_bit, fall);
            bus.RX_IN = 1'b1;
            repeat (2 * vecs[v].p + 20) @(negedge CLK);
            check($sformatf("vec%0d_vld_count", v),  vld_cyc.size(),  vecs[v].exp_vld);
            check($sformatf("vec%0d_perr_count", v), perr_cyc.size(), vecs[v].exp_perr);
            check($sformatf("vec%0d_serr_count", v), serr_cyc.size(), vecs[v].exp_serr);
            check($sformatf("vec%0d_p_data", v), int'(bus.P_DATA), int'(vecs[v].exp_pdata));
            first = -1;
            if (vld_cyc.size() > 0)  first = vld_cyc[0];
            if (perr_cyc.size() > 0 && (first < 0 || perr_cyc[0] < first)) first = perr_cyc[0];
            if (serr_cyc.size() > 0 && (first < 0 || serr_cyc[0] < first)) first = serr_cyc[0];
            check($sformatf("vec%0d_latency", v), first - fall,
                  (10 + int'(vecs[v].pe)) * vecs[v].p + 3);
        end

        // Two-cycle low glitch is rejected, following frame is clean.
        clear_mon();
        config_frame(8, 1'b0, 1'b0);
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        bus.RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        check("glitch_no_pulse", vld_cyc.size() + perr_cyc.size() + serr_cyc.size(), 0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, fall);
        repeat (30) @(negedge CLK);
        check("glitch_next_vld",    vld_cyc.size(), 1);
        check("glitch_next_p_data", int'(bus.P_DATA), 8'h55);
        if (vld_cyc.size() > 0) check("glitch_next_latency", vld_cyc[0] - fall, 83);

        // Back-to-back frames at P=32 with no idle gap.
        clear_mon();
        config_frame(32, 1'b0, 1'b0);
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, fall);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, first);
        send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b1, first);
        bus.RX_IN = 1'b1;
        repeat (100) @(negedge CLK);
        check("b2b_vld_count", vld_cyc.size(), 3);
        check("b2b_err_count", perr_cyc.size() + serr_cyc.size(), 0);
        if (vld_cyc.size() == 3) begin
            check("b2b_latency", vld_cyc[0] - fall, 323);
            check("b2b_gap1", vld_cyc[1] - vld_cyc[0], 320);
            check("b2b_gap2", vld_cyc[2] - vld_cyc[1], 320);
            check("b2b_data0", int'(vld_dat[0]), 8'h00);
            check("b2b_data1", int'(vld_dat[1]), 8'hFF);
            check("b2b_data2", int'(vld_dat[2]), 8'h5A);
        end

        // Line held low: periodic stop errors, never a valid byte.
        clear_mon();
        config_frame(8, 1'b0, 1'b0);
        fall = cyc;
        bus.RX_IN = 1'b0;
        repeat (242) @(negedge CLK);
        bus.RX_IN = 1'b1;
        repeat (60) @(negedge CLK);
        check("break_serr_count", serr_cyc.size(), 3);
        check("break_vld_count",  vld_cyc.size() + perr_cyc.size(), 0);
        if (serr_cyc.size() == 3) begin
            check("break_first", serr_cyc[0] - fall, 83);
            check("break_period", serr_cyc[2] - serr_cyc[0], 160);
        end

        // Reset in the middle of a frame aborts it.
        clear_mon();
        config_frame(8, 1'b0, 1'b0);
        drive(1'b0, 8);
        drive(1'b1, 8);
        drive(1'b1, 8);
        drive(1'b1, 8);
        RST = 1'b1;
        #1;
        check("midrst_p_data",   int'(bus.P_DATA),   0);
        check("midrst_data_vld", int'(bus.DATA_VLD), 0);
        check("midrst_par_err",  int'(bus.PAR_ERR),  0);
        check("midrst_stp_err",  int'(bus.STP_ERR),  0);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        check("midrst_no_pulse", vld_cyc.size() + perr_cyc.size() + serr_cyc.size(), 0);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, fall);
        repeat (30) @(negedge CLK);
        check("postrst_vld",    vld_cyc.size(), 1);
        check("postrst_p_data", int'(bus.P_DATA), 8'h12);
        if (vld_cyc.size() > 0) check("postrst_latency", vld_cyc[0] - fall, 83);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
